// File: rtl/branch_resolve_stage.sv
// Execute-stage back end sitting after the ALU. It registers the ALU outcome,
// keeps the {carry, zero, sign} flag register and resolves branches. It emits
// one writeback/redirect record per accepted instruction. After a taken
// branch it drops the next FLUSH_SLOTS accepted wrong-path instructions.
//
// Handshake: a record moves on a rising edge only when valid and ready are
// both high on that edge. While out_valid is high and out_ready is low, every
// output holds steady. in_ready = !out_valid || out_ready, so the stage can
// dequeue the old record and load a new one on the same edge.
module branch_resolve_stage #(
    parameter int DATA_W      = 32,
    parameter int PC_W        = 32,
    parameter int FLUSH_SLOTS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_carry,
    input  logic              flag_we,
    input  logic [3:0]        branch_op,
    input  logic [PC_W-1:0]   pc_plus4,
    input  logic [PC_W-1:0]   branch_tgt,
    input  logic              wb_req,
    input  logic [4:0]        rd_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              wb_en,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              redirect,
    output logic [PC_W-1:0]   next_pc,
    output logic [2:0]        flags
);

    localparam logic [3:0] OP_B    = 4'd1;
    localparam logic [3:0] OP_BR   = 4'd2;
    localparam logic [3:0] OP_BLTZ = 4'd3;
    localparam logic [3:0] OP_BZ   = 4'd4;
    localparam logic [3:0] OP_BNZ  = 4'd5;
    localparam logic [3:0] OP_BL   = 4'd6;
    localparam logic [3:0] OP_BCY  = 4'd7;
    localparam logic [3:0] OP_BNCY = 4'd8;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_SLOTS);
    localparam logic [4:0] LINK_REG   = 5'd31;

    // Number of accepted wrong-path slots still to be dropped.
    logic [2:0]        flush_cnt;
    logic              accept;
    logic              squash;
    logic              taken;
    logic [PC_W-1:0]   target;
    logic              wb_en_d;
    logic [4:0]        wb_rd_d;
    logic [DATA_W-1:0] wb_data_d;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign squash   = (flush_cnt != 3'd0);

    // Branch decision. bcy/bncy look at the carry flag as it was before this
    // instruction, even when the same instruction also writes the flags.
    always_comb begin
        taken  = 1'b0;
        target = branch_tgt;
        case (branch_op)
            OP_B:    taken = 1'b1;
            OP_BR: begin
                taken  = 1'b1;
                target = PC_W'(alu_result);
            end
            OP_BLTZ: taken = alu_result[DATA_W-1];
            OP_BZ:   taken = alu_zero;
            OP_BNZ:  taken = !alu_zero;
            OP_BL:   taken = 1'b1;
            OP_BCY:  taken = flags[2];
            OP_BNCY: taken = !flags[2];
            default: taken = 1'b0;
        endcase
    end

    // Writeback selection. bl links pc_plus4 into r31.
    always_comb begin
        wb_en_d   = wb_req;
        wb_rd_d   = rd_in;
        wb_data_d = alu_result;
        if (branch_op == OP_BL) begin
            wb_en_d   = 1'b1;
            wb_rd_d   = LINK_REG;
            wb_data_d = DATA_W'(pc_plus4);
        end
    end

    // Output record, flag register and squash counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            wb_en     <= 1'b0;
            wb_rd     <= 5'd0;
            wb_data   <= '0;
            redirect  <= 1'b0;
            next_pc   <= '0;
            flags     <= 3'b000;
            flush_cnt <= 3'd0;
        end else if (accept) begin
            if (squash) begin
                flush_cnt <= flush_cnt - 3'd1;
                out_valid <= 1'b0;
            end else begin
                out_valid <= 1'b1;
                wb_en     <= wb_en_d;
                wb_rd     <= wb_rd_d;
                wb_data   <= wb_data_d;
                redirect  <= taken;
                next_pc   <= taken ? target : pc_plus4;
                if (flag_we) begin
                    flags <= {alu_carry, alu_zero, alu_result[DATA_W-1]};
                end
                flush_cnt <= taken ? FLUSH_INIT : 3'd0;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_branch_resolve_stage.sv
// Directed bench for branch_resolve_stage. An instruction-level model tracks
// the expected record, flags and squash budget. A per-cycle compare process
// checks the DUT against that model. Directed steps add literal checks.
module tb_branch_resolve_stage;

    localparam int DATA_W = 32;
    localparam int PC_W   = 32;
    localparam int FLUSH  = 2;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              alu_carry;
    logic              flag_we;
    logic [3:0]        branch_op;
    logic [PC_W-1:0]   pc_plus4;
    logic [PC_W-1:0]   branch_tgt;
    logic              wb_req;
    logic [4:0]        rd_in;
    logic              out_valid;
    logic              out_ready;
    logic              wb_en;
    logic [4:0]        wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              redirect;
    logic [PC_W-1:0]   next_pc;
    logic [2:0]        flags;

    int n_tests;
    int n_fail;

    branch_resolve_stage #(.DATA_W(DATA_W), .PC_W(PC_W), .FLUSH_SLOTS(FLUSH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .flag_we(flag_we), .branch_op(branch_op), .pc_plus4(pc_plus4),
        .branch_tgt(branch_tgt), .wb_req(wb_req), .rd_in(rd_in),
        .out_valid(out_valid), .out_ready(out_ready), .wb_en(wb_en),
        .wb_rd(wb_rd), .wb_data(wb_data), .redirect(redirect),
        .next_pc(next_pc), .flags(flags)
    );

    // Clock and reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic              m_valid;
    logic [2:0]        m_flags;
    int                m_flush;
    logic              m_wb_en;
    logic [4:0]        m_wb_rd;
    logic [DATA_W-1:0] m_wb_data;
    logic              m_redirect;
    logic [PC_W-1:0]   m_next_pc;

    function automatic logic f_taken(input logic [3:0] op, input logic [DATA_W-1:0] res,
                                     input logic z, input logic cflag);
        case (op)
            4'd1, 4'd2, 4'd6: return 1'b1;
            4'd3:             return res[DATA_W-1];
            4'd4:             return z;
            4'd5:             return !z;
            4'd7:             return cflag;
            4'd8:             return !cflag;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic [PC_W-1:0] f_npc(input logic [3:0] op, input logic [DATA_W-1:0] res,
                                              input logic z, input logic cflag,
                                              input logic [PC_W-1:0] pc4, input logic [PC_W-1:0] tgt);
        if (!f_taken(op, res, z, cflag)) return pc4;
        if (op == 4'd2) return res;
        return tgt;
    endfunction

    // Model update once per instruction-level event at each edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0; m_flags <= 3'b000; m_flush <= 0;
            m_wb_en <= 1'b0; m_wb_rd <= 5'd0; m_wb_data <= '0;
            m_redirect <= 1'b0; m_next_pc <= '0;
        end else if (in_valid && (!m_valid || out_ready)) begin
            if (m_flush > 0) begin
                m_flush <= m_flush - 1;
                m_valid <= 1'b0;
            end else begin
                m_valid    <= 1'b1;
                m_wb_en    <= (branch_op == 4'd6) ? 1'b1 : wb_req;
                m_wb_rd    <= (branch_op == 4'd6) ? 5'd31 : rd_in;
                m_wb_data  <= (branch_op == 4'd6) ? pc_plus4 : alu_result;
                m_redirect <= f_taken(branch_op, alu_result, alu_zero, m_flags[2]);
                m_next_pc  <= f_npc(branch_op, alu_result, alu_zero, m_flags[2], pc_plus4, branch_tgt);
                if (flag_we) m_flags <= {alu_carry, alu_zero, alu_result[DATA_W-1]};
                m_flush    <= f_taken(branch_op, alu_result, alu_zero, m_flags[2]) ? FLUSH : 0;
            end
        end else if (out_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Per-cycle compare against the model.
    always begin
        @(posedge clk);
        #1;
        n_tests++;
        if (in_ready !== (!m_valid || out_ready) || out_valid !== m_valid || flags !== m_flags ||
            (m_valid && (wb_en !== m_wb_en || wb_rd !== m_wb_rd || wb_data !== m_wb_data ||
                         redirect !== m_redirect || next_pc !== m_next_pc))) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t got v=%b rdy=%b f=%b en=%b rd=%0d d=%h r=%b pc=%h want v=%b f=%b en=%b rd=%0d d=%h r=%b pc=%h",
                     $time, out_valid, in_ready, flags, wb_en, wb_rd, wb_data, redirect, next_pc,
                     m_valid, m_flags, m_wb_en, m_wb_rd, m_wb_data, m_redirect, m_next_pc);
        end
    end

    // ---------------- driver / check tasks ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] res, input logic z,
                         input logic c, input logic fwe, input logic wbr, input logic [4:0] rd,
                         input logic [31:0] pc4, input logic [31:0] tgt);
        branch_op = op; alu_result = res; alu_zero = z; alu_carry = c; flag_we = fwe;
        wb_req = wbr; rd_in = rd; pc_plus4 = pc4; branch_tgt = tgt; in_valid = 1'b1;
    endtask

    // Present one instruction, wait (bounded) for acceptance, then return
    // 2 time units after the accepting edge with in_valid dropped.
    task automatic send(input logic [3:0] op, input logic [31:0] res, input logic z,
                        input logic c, input logic fwe, input logic wbr, input logic [4:0] rd,
                        input logic [31:0] pc4, input logic [31:0] tgt);
        int wait_cnt;
        @(negedge clk);
        drive(op, res, z, c, fwe, wbr, rd, pc4, tgt);
        #1;
        wait_cnt = 0;
        while (!in_ready && wait_cnt < 50) begin
            @(negedge clk); #1;
            wait_cnt++;
        end
        if (!in_ready) begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout got in_ready=%b want 1", in_ready);
        end
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    // Two filler instructions that must be squashed after a redirect.
    task automatic flush_two(input string name);
        send(4'd0, 32'h1111_0000, 1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 32'h0, 32'h0);
        check({name, "_sq1_valid"}, out_valid, 1'b0);
        send(4'd1, 32'h2222_0000, 1'b0, 1'b1, 1'b1, 1'b1, 5'd9, 32'h0, 32'h0);
        check({name, "_sq2_valid"}, out_valid, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b1; out_ready = 1'b1;
        drive(4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_flags", flags, 3'b000);
        check("rst_next_pc", next_pc, 32'h0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1'b1);

        // ADD writing r5, sign set.
        send(4'd0, 32'hC52A_BD9A, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 32'h0000_0024, 32'h0);
        check("add_valid", out_valid, 1'b1);
        check("add_wb_en", wb_en, 1'b1);
        check("add_wb_rd", wb_rd, 5'd5);
        check("add_wb_data", wb_data, 32'hC52A_BD9A);
        check("add_flags", flags, 3'b001);
        check("add_redirect", redirect, 1'b0);
        check("add_next_pc", next_pc, 32'h0000_0024);

        // bz taken, then two squashed slots, then a normal record.
        send(4'd4, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0000_0044, 32'h0000_0100);
        check("bz_redirect", redirect, 1'b1);
        check("bz_next_pc", next_pc, 32'h0000_0100);
        flush_two("bz");
        check("bz_flags_kept", flags, 3'b001);
        send(4'd0, 32'h0000_00AB, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 32'h0000_0104, 32'h0);
        check("post_flush_valid", out_valid, 1'b1);
        check("post_flush_data", wb_data, 32'h0000_00AB);

        // bl links into r31.
        send(4'd6, 32'h5, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 32'h0000_0080, 32'h0000_0200);
        check("bl_wb_en", wb_en, 1'b1);
        check("bl_wb_rd", wb_rd, 5'd31);
        check("bl_wb_data", wb_data, 32'h0000_0080);
        check("bl_redirect", redirect, 1'b1);
        check("bl_next_pc", next_pc, 32'h0000_0200);
        flush_two("bl");

        // Carry-flag branches.
        send(4'd0, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 1'b1, 5'd2, 32'h0000_0010, 32'h0);
        check("setc_flags", flags, 3'b100);
        send(4'd7, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0000_0014, 32'h0000_0300);
        check("bcy_redirect", redirect, 1'b1);
        check("bcy_next_pc", next_pc, 32'h0000_0300);
        flush_two("bcy");
        send(4'd8, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0000_0050, 32'h0000_0300);
        check("bncy_redirect", redirect, 1'b0);
        check("bncy_next_pc", next_pc, 32'h0000_0050);
        send(4'd7, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0000_0060, 32'h0000_0340);
        check("bcy_we_redirect", redirect, 1'b1);
        check("bcy_we_next_pc", next_pc, 32'h0000_0340);
        check("bcy_we_flags", flags, 3'b010);
        flush_two("bcy_we");

        // Backpressure: hold record A for 3 cycles, then dequeue + accept B.
        send(4'd0, 32'hAAAA_0001, 1'b0, 1'b0, 1'b0, 1'b1, 5'd10, 32'h0000_0070, 32'h0);
        @(negedge clk);
        out_ready = 1'b0;
        drive(4'd0, 32'hBBBB_0002, 1'b0, 1'b0, 1'b0, 1'b1, 5'd11, 32'h0000_0074, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            check("hold_valid", out_valid, 1'b1);
            check("hold_ready", in_ready, 1'b0);
            check("hold_data", wb_data, 32'hAAAA_0001);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("release_ready", in_ready, 1'b1);
        @(posedge clk); #2;
        in_valid = 1'b0;
        check("b2b_valid", out_valid, 1'b1);
        check("b2b_data", wb_data, 32'hBBBB_0002);
        check("b2b_rd", wb_rd, 5'd11);

        // Reset during a hold.
        @(negedge clk);
        out_ready = 1'b0;
        drive(4'd0, 32'hCCCC_0003, 1'b0, 1'b0, 1'b0, 1'b1, 5'd12, 32'h0, 32'h0);
        @(posedge clk); #2;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_hold_valid", out_valid, 1'b0);
        check("rst_hold_data", wb_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;

        // Reset during a flush window: the next record must not be squashed.
        send(4'd1, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0000_0090, 32'h0000_0400);
        check("b_redirect", redirect, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_flush_valid", out_valid, 1'b0);
        check("rst_flush_redirect", redirect, 1'b0);
        check("rst_flush_flags", flags, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_flush_ready", in_ready, 1'b1);
        send(4'd0, 32'h0000_0077, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h0000_0004, 32'h0);
        check("after_rst_valid", out_valid, 1'b1);
        check("after_rst_data", wb_data, 32'h0000_0077);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
